redi_ctrl: RTL
==============

# redi_ctrl

Forwarding and load-use hazard controller for the 5-stage pipeline. It is the producer of the `ALUREDI`/`SYSREDI` redirect vectors that the EX-stage ALU/syscall operand muxes consume. It tracks the destination register of every instruction in flight through EX, MEM and WB. On each ID→EX advance it issues registered redirect codes selecting R (EX/MEM result) or WB (MEM/WB result) in place of the register-file operands. It also raises a one-cycle stall for load-use hazards and counts stalls.

## Interface

Parameters:
- `CNTW`, default 16: width of the saturating stall counter.

Ports:
- `in_CLK`  in  1  clock, rising edge.
- `in_RST`  in  1  reset, asynchronous, active-high.
- `in_LOCK`  in  1  syscall lock; freezes all state while high.
- `in_FLUSH`  in  1  branch/jump taken; the next EX slot becomes a bubble.
- `in_IDX`  in  5  register number feeding ALU X in the ID instruction (rs, or rt when X takes B).
- `in_IDXUSE`  in  1  ID instruction reads `in_IDX` as X.
- `in_IDY`  in  5  register number feeding ALU Y (rt, or rs when Y takes A).
- `in_IDYUSE`  in  1  ID instruction reads `in_IDY` as Y.
- `in_IDSYS`  in  1  ID instruction is `syscall` (implicit reads of $v0 = 2 and $a0 = 4).
- `in_IDWE`  in  1  ID instruction writes a register.
- `in_IDDST`  in  5  destination register of the ID instruction.
- `in_IDLOAD`  in  1  ID instruction is a load (result available only at WB).
- `out_ALUREDI`  out  4  [0] X←R, [1] Y←R, [2] X←WB, [3] Y←WB; registered.
- `out_SYSREDI`  out  4  [0] v0←R, [1] a0←R, [2] v0←WB, [3] a0←WB; registered.
- `out_STALL`  out  1  hold PC and IF/ID; combinational.
- `out_STALLCNT`  out  CNTW  total stall cycles, saturating.

## Operation

- State:
  - EX slot: `ex_we`, `ex_dst`, `ex_load`.
  - MEM slot: `mem_we`, `mem_dst`.
  - Redirect regs: `out_ALUREDI`, `out_SYSREDI`.
  - `out_STALLCNT`.
- Hazard test for a source register s: a match against a slot requires we=1, dst==s and s≠0. Register 0 never matches.
- Load-use stall:
  - `out_STALL` = !in_FLUSH && !in_LOCK && ex_we && ex_load && ex_dst≠0.
  - In addition, the EX destination must match one of: X (with `in_IDXUSE`), Y (with `in_IDYUSE`), or 2/4 (with `in_IDSYS`).
- Per-cycle update, in priority order:
  1. `in_LOCK`=1: hold every register, including the counter.
  2. `in_FLUSH`=1: EX←bubble (we=0, load=0); MEM←old EX; redirect regs←0.
  3. `out_STALL`=1: EX←bubble; MEM←old EX; redirect regs←0; counter+1, saturating at all-ones.
  4. Normal: EX←ID fields (`in_IDWE`, `in_IDDST`, `in_IDLOAD`); MEM←old EX; redirect regs take the codes below.
- Redirect codes, computed from the pre-edge EX/MEM slots (these become MEM/WB when the instruction reaches EX):
  - X←R when `in_IDXUSE` and X matches EX and !ex_load.
  - X←WB when `in_IDXUSE` and X matches MEM and X←R is not set.
  - Y is handled the same way using bits [1]/[3].
  - With `in_IDSYS`, $v0 (2) is handled the same way into SYSREDI[0]/[2], and $a0 (4) into [1]/[3].
  - Without `in_IDSYS`, `out_SYSREDI`=0.
- Invariant: the R and WB bits for the same operand are never set together. R (newer) always beats WB.
- A load matching at EX never produces R; that case is a stall. After the bubble the load sits in MEM, giving a WB redirect.
- Instructions older than WB are served by the register file (write-before-read), so they need no redirect.

## Timing

- Reset (asynchronous, immediate): all outputs 0, all slots we=0.
- Redirect latency: codes are computed in the ID cycle and valid for the whole following EX cycle.
- `out_STALL` follows its inputs combinationally in the same cycle. A single load-use hazard gives exactly 1 stall cycle. The re-presented ID instruction then sees the load in MEM and gets WB forwarding.
- FLUSH together with a stall condition: flush wins, `out_STALL`=0, counter unchanged.
- LOCK together with FLUSH or STALL: nothing changes and `out_STALL`=0. Those events take effect on the first cycle with `in_LOCK`=0 if the inputs are still present.
- Counter at all-ones: it stays at all-ones.
- Reset asserted mid-stall: the pipeline is cleared and `out_STALL` drops asynchronously.

## Test plan

- Back-to-back ALU: `add $3` then `sub` with X=$3 → in the second instruction's EX cycle, `out_ALUREDI`=4'b0001.
- Distance 2: `add $5`, nop, then Y=$5 → `out_ALUREDI`=4'b1000. With `add $5` twice in a row, then Y=$5 → 4'b0010 (R wins).
- Load-use: `lw $8`, then X=$8 → `out_STALL`=1 for one cycle, `out_STALLCNT`=1, EX gets a bubble. The next EX cycle has `out_ALUREDI`=4'b0100.
- Syscall: `addi $2` then syscall with `in_IDSYS`=1 → `out_SYSREDI`=4'b0001. `addi $0` in the same position → all redirect bits 0.
- FLUSH asserted together with a load-use condition → `out_STALL`=0, redirects 0, counter unchanged. `in_LOCK` held 3 cycles → all state frozen, then resumes.
- With CNTW=2, apply 5 load-use stalls → counter reads 3 (saturated). Then asynchronous `in_RST` mid-cycle → all outputs read 0 immediately.

Source files
------------

// File: rtl/redi_ctrl_if.sv
// Bundle between the ID-stage decode and the forwarding/hazard controller.
// The decode side presents the ID instruction's operand usage and destination
// every cycle. The controller answers with registered redirect codes for the
// EX operand muxes, a combinational stall and a saturating stall count.
// No valid/ready pairing: every field is sampled on each rising clock edge
// unless in_LOCK is high.
interface redi_ctrl_if #(
    parameter int CNTW = 16
);
    logic            in_LOCK;
    logic            in_FLUSH;
    logic [4:0]      in_IDX;
    logic            in_IDXUSE;
    logic [4:0]      in_IDY;
    logic            in_IDYUSE;
    logic            in_IDSYS;
    logic            in_IDWE;
    logic [4:0]      in_IDDST;
    logic            in_IDLOAD;
    logic [3:0]      out_ALUREDI;
    logic [3:0]      out_SYSREDI;
    logic            out_STALL;
    logic [CNTW-1:0] out_STALLCNT;

    modport master (
        output in_LOCK, in_FLUSH, in_IDX, in_IDXUSE, in_IDY, in_IDYUSE,
               in_IDSYS, in_IDWE, in_IDDST, in_IDLOAD,
        input  out_ALUREDI, out_SYSREDI, out_STALL, out_STALLCNT
    );

    modport slave (
        input  in_LOCK, in_FLUSH, in_IDX, in_IDXUSE, in_IDY, in_IDYUSE,
               in_IDSYS, in_IDWE, in_IDDST, in_IDLOAD,
        output out_ALUREDI, out_SYSREDI, out_STALL, out_STALLCNT
    );
endinterface

// File: rtl/redi_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// It tracks the destination of the instructions in EX and MEM. On every
// ID->EX advance it registers redirect codes:
//   R  = EX/MEM result, used when the producer is one stage ahead.
//   WB = MEM/WB result, used when the producer is two stages ahead.
// A load one stage ahead cannot be forwarded, so it raises a single-cycle
// stall and inserts a bubble.
module redi_ctrl #(
    parameter int CNTW = 16
) (
    input logic        in_CLK,
    input logic        in_RST,
    redi_ctrl_if.slave bus
);
    localparam logic [4:0] REG_V0 = 5'd2;
    localparam logic [4:0] REG_A0 = 5'd4;

    // Producer slots: EX holds the instruction one ahead of ID, MEM the one two ahead.
    logic            ex_we;
    logic [4:0]      ex_dst;
    logic            ex_load;
    logic            mem_we;
    logic [4:0]      mem_dst;

    logic [3:0]      alu_redi;
    logic [3:0]      sys_redi;
    logic [CNTW-1:0] stall_cnt;

    // Per-operand hits against the EX and MEM slots.
    logic x_ex, y_ex, v0_ex, a0_ex;
    logic x_mem, y_mem, v0_mem, a0_mem;
    logic x_r, y_r, v0_r, a0_r;
    logic load_use;
    logic stall;
    logic [3:0] alu_next;
    logic [3:0] sys_next;

    // A slot supplies a source only if it writes, targets that register, and the register is not $0.
    function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst == src) && (src != 5'd0);
    endfunction

    assign x_ex   = bus.in_IDXUSE && hit(ex_we, ex_dst, bus.in_IDX);
    assign y_ex   = bus.in_IDYUSE && hit(ex_we, ex_dst, bus.in_IDY);
    assign v0_ex  = bus.in_IDSYS  && hit(ex_we, ex_dst, REG_V0);
    assign a0_ex  = bus.in_IDSYS  && hit(ex_we, ex_dst, REG_A0);
    assign x_mem  = bus.in_IDXUSE && hit(mem_we, mem_dst, bus.in_IDX);
    assign y_mem  = bus.in_IDYUSE && hit(mem_we, mem_dst, bus.in_IDY);
    assign v0_mem = bus.in_IDSYS  && hit(mem_we, mem_dst, REG_V0);
    assign a0_mem = bus.in_IDSYS  && hit(mem_we, mem_dst, REG_A0);

    // A load in EX never forwards as R; that case becomes a stall instead.
    assign x_r  = x_ex  && !ex_load;
    assign y_r  = y_ex  && !ex_load;
    assign v0_r = v0_ex && !ex_load;
    assign a0_r = a0_ex && !ex_load;

    assign load_use = ex_load && (x_ex || y_ex || v0_ex || a0_ex);
    assign stall    = !bus.in_FLUSH && !bus.in_LOCK && load_use;

    // R (newer producer) suppresses WB for the same operand.
    assign alu_next = {y_mem && !y_r, x_mem && !x_r, y_r, x_r};
    assign sys_next = {a0_mem && !a0_r, v0_mem && !v0_r, a0_r, v0_r};

    // Pipeline slot tracking, redirect registers and the saturating stall counter.
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            ex_we     <= 1'b0;
            ex_dst    <= 5'd0;
            ex_load   <= 1'b0;
            mem_we    <= 1'b0;
            mem_dst   <= 5'd0;
            alu_redi  <= 4'd0;
            sys_redi  <= 4'd0;
            stall_cnt <= '0;
        end else if (!bus.in_LOCK) begin
            mem_we  <= ex_we;
            mem_dst <= ex_dst;
            if (bus.in_FLUSH || stall) begin
                ex_we    <= 1'b0;
                ex_dst   <= 5'd0;
                ex_load  <= 1'b0;
                alu_redi <= 4'd0;
                sys_redi <= 4'd0;
                if (stall && (stall_cnt != {CNTW{1'b1}})) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end else begin
                ex_we    <= bus.in_IDWE;
                ex_dst   <= bus.in_IDDST;
                ex_load  <= bus.in_IDLOAD;
                alu_redi <= alu_next;
                sys_redi <= bus.in_IDSYS ? sys_next : 4'd0;
            end
        end
    end

    assign bus.out_ALUREDI  = alu_redi;
    assign bus.out_SYSREDI  = sys_redi;
    assign bus.out_STALL    = stall;
    assign bus.out_STALLCNT = stall_cnt;
endmodule
